// File: rtl/tc_operand_pipe.sv
// Two-stage operand conditioning pipe: per-element sign extraction and
// magnitude (two's complement) for signed lanes of a multiplier operand.
module tc_operand_pipe #(
  parameter int LANE_W      = 8,
  parameter int NUM_LANES   = 4,
  parameter int OPERAND_SEL = 0,
  localparam int DATA_W     = LANE_W * NUM_LANES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_operand,
  input  logic [1:0]           in_opcode,
  input  logic [1:0]           in_precision,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_operand,
  output logic [NUM_LANES-1:0] out_sign,
  output logic [1:0]           out_opcode,
  output logic [1:0]           out_precision
);

  logic                 s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]    s1_op_q, s1_op_d;
  logic [1:0]           s1_opc_q, s1_opc_d;
  logic [1:0]           s1_prec_q, s1_prec_d;
  logic [NUM_LANES-1:0] s1_sign_q, s1_sign_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]    s2_op_q, s2_op_d;
  logic [1:0]           s2_opc_q, s2_opc_d;
  logic [1:0]           s2_prec_q, s2_prec_d;
  logic [NUM_LANES-1:0] s2_sign_q, s2_sign_d;

  logic s1_adv, s2_adv;
  logic in_signed;
  logic in_p1, in_p2, s1_p1, s1_p2;
  logic [NUM_LANES-1:0] lane_msb;
  logic [NUM_LANES-1:0] sign_in;
  logic [NUM_LANES-1:0] carry;
  logic [DATA_W-1:0]    cond;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  assign in_signed = (OPERAND_SEL == 0) ? (in_opcode != 2'b10)
                                        : ~in_opcode[1];
  assign in_p1 = (in_precision == 2'b01);
  assign in_p2 = (in_precision == 2'b10);
  assign s1_p1 = (s1_prec_q == 2'b01);
  assign s1_p2 = (s1_prec_q == 2'b10);

  // Element MSB lane is k|(G-1) since elements are aligned to bit 0.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_sign
    assign lane_msb[k] = in_operand[k*LANE_W + LANE_W - 1];
    assign sign_in[k]  = in_signed & (in_p2 ? lane_msb[k | 3] :
                                      in_p1 ? lane_msb[k | 1] :
                                              lane_msb[k]);
  end

  // ~x + 1 per element; carry out of a lane only when the lane is zero.
  assign carry[0] = 1'b0;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_neg
    localparam bit ST4 = (k % 4 == 0);
    localparam bit ST2 = (k % 2 == 0);
    logic          start, cin, flg;
    logic [LANE_W-1:0] x;
    assign flg   = s1_sign_q[k];
    assign x     = s1_op_q[k*LANE_W +: LANE_W];
    assign start = ST4 | (ST2 & ~s1_p2) | (~s1_p1 & ~s1_p2);
    assign cin   = start | carry[k];
    assign cond[k*LANE_W +: LANE_W] =
      (x ^ {LANE_W{flg}}) + LANE_W'(flg & cin);
    if (k < NUM_LANES - 1) begin : g_c
      assign carry[k+1] = flg & cin & ~(|x);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_opc_d   = s1_opc_q;
    s1_prec_d  = s1_prec_q;
    s1_sign_d  = s1_sign_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d   = in_operand;
        s1_opc_d  = in_opcode;
        s1_prec_d = in_precision;
        s1_sign_d = sign_in;
      end
    end
    if (flush) s1_valid_d = 1'b0;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_op_d    = s2_op_q;
    s2_opc_d   = s2_opc_q;
    s2_prec_d  = s2_prec_q;
    s2_sign_d  = s2_sign_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_op_d   = cond;
        s2_opc_d  = s1_opc_q;
        s2_prec_d = s1_prec_q;
        s2_sign_d = s1_sign_q;
      end
    end
    if (flush) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_opc_q   <= '0;
      s1_prec_q  <= '0;
      s1_sign_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_op_q    <= '0;
      s2_opc_q   <= '0;
      s2_prec_q  <= '0;
      s2_sign_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_opc_q   <= s1_opc_d;
      s1_prec_q  <= s1_prec_d;
      s1_sign_q  <= s1_sign_d;
      s2_valid_q <= s2_valid_d;
      s2_op_q    <= s2_op_d;
      s2_opc_q   <= s2_opc_d;
      s2_prec_q  <= s2_prec_d;
      s2_sign_q  <= s2_sign_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_operand   = s2_op_q;
  assign out_sign      = s2_sign_q;
  assign out_opcode    = s2_opc_q;
  assign out_precision = s2_prec_q;

endmodule

// File: tb/tb_tc_operand_pipe.sv
// Directed bench for tc_operand_pipe: conditioning vectors, backpressure,
// reset and flush, on an operand-A and an operand-B instance.
module tb_tc_operand_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_operand;
  logic [1:0]  in_opcode, in_precision;

  logic        ir0, ov0, ir1, ov1;
  logic [31:0] oop0, oop1;
  logic [3:0]  osg0, osg1;
  logic [1:0]  ooc0, ooc1, opr0, opr1;

  int vectors = 0;
  int miss    = 0;
  int acc, nxt, rx;
  logic [31:0] rxv [8];

  always #5 clk = ~clk;

  tc_operand_pipe #(.LANE_W(8), .NUM_LANES(4), .OPERAND_SEL(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0),
    .in_operand(in_operand), .in_opcode(in_opcode),
    .in_precision(in_precision),
    .out_valid(ov0), .out_ready(out_ready),
    .out_operand(oop0), .out_sign(osg0),
    .out_opcode(ooc0), .out_precision(opr0)
  );

  tc_operand_pipe #(.LANE_W(8), .NUM_LANES(4), .OPERAND_SEL(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1),
    .in_operand(in_operand), .in_opcode(in_opcode),
    .in_precision(in_precision),
    .out_valid(ov1), .out_ready(out_ready),
    .out_operand(oop1), .out_sign(osg1),
    .out_opcode(ooc1), .out_precision(opr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] op, input logic [1:0] opc,
                       input logic [1:0] prec);
    in_valid     = 1'b1;
    in_operand   = op;
    in_opcode    = opc;
    in_precision = prec;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_operand = '0; in_opcode = '0; in_precision = '0;

    @(negedge clk);
    chk("rst_valid", {31'b0, ov0}, 32'd0);
    chk("rst_operand", oop0, 32'd0);
    chk("rst_sign", {28'b0, osg0}, 32'd0);
    chk("rst_opc_prec", {28'b0, ooc0, opr0}, 32'd0);
    rst = 1'b0;
    #1 chk("rst_in_ready", {31'b0, ir0}, 32'd1);

    // Basic MUL at 8-bit lanes, latency check
    @(negedge clk); drive(32'h80FF017F, 2'b00, 2'b00);
    @(negedge clk); in_valid = 1'b0;
    #1 chk("lat_not_early", {31'b0, ov0}, 32'd0);
    @(negedge clk);
    chk("mul8_valid", {31'b0, ov0}, 32'd1);
    chk("mul8_data", oop0, 32'h8001017F);
    chk("mul8_sign", {28'b0, osg0}, 32'hC);
    chk("mul8_opc_prec", {28'b0, ooc0, opr0}, 32'h0);
    @(negedge clk);
    chk("mul8_single", {31'b0, ov0}, 32'd0);

    // MULH 16-bit elements, then precision 11 aliasing 8-bit
    drive(32'hFFFE8000, 2'b01, 2'b01);
    @(negedge clk); drive(32'h00FF0000, 2'b01, 2'b11);
    @(negedge clk); in_valid = 1'b0;
    chk("mulh16_data", oop0, 32'h00028000);
    chk("mulh16_sign", {28'b0, osg0}, 32'hF);
    chk("mulh16_prec", {30'b0, opr0}, 32'h1);
    @(negedge clk);
    chk("p11_data", oop0, 32'h00010000);
    chk("p11_sign", {28'b0, osg0}, 32'h4);
    chk("p11_prec", {30'b0, opr0}, 32'h3);

    // 32-bit elements: MULHU unsigned, then MUL back-to-back
    @(negedge clk); drive(32'hFFFFFFFF, 2'b10, 2'b10);
    @(negedge clk); drive(32'hFFFFFFFF, 2'b00, 2'b10);
    @(negedge clk); in_valid = 1'b0;
    chk("mulhu32_data", oop0, 32'hFFFFFFFF);
    chk("mulhu32_sign", {28'b0, osg0}, 32'h0);
    @(negedge clk);
    chk("mul32_valid", {31'b0, ov0}, 32'd1);
    chk("mul32_data", oop0, 32'h00000001);
    chk("mul32_sign", {28'b0, osg0}, 32'hF);

    // Operand B: MULSU unsigned, MUL signed; operand A MULSU signed
    @(negedge clk); drive(32'h80808080, 2'b11, 2'b00);
    @(negedge clk); drive(32'h80808080, 2'b00, 2'b00);
    @(negedge clk); in_valid = 1'b0;
    chk("b_mulsu_data", oop1, 32'h80808080);
    chk("b_mulsu_sign", {28'b0, osg1}, 32'h0);
    chk("a_mulsu_sign", {28'b0, osg0}, 32'hF);
    chk("a_mulsu_data", oop0, 32'h80808080);
    @(negedge clk);
    chk("b_mul_data", oop1, 32'h80808080);
    chk("b_mul_sign", {28'b0, osg1}, 32'hF);

    // Backpressure: beats 1..5, out_ready low for 4 cycles
    @(negedge clk);
    out_ready = 1'b0; nxt = 1; acc = 0;
    drive(32'd1, 2'b00, 2'b00);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c >= 2) begin
        chk("bp_stall_valid", {31'b0, ov0}, 32'd1);
        chk("bp_stall_data", oop0, 32'd1);
        chk("bp_stall_opc", {28'b0, ooc0, opr0}, 32'd0);
      end
      if (ir0) begin acc++; nxt++; end
      @(negedge clk);
      in_operand = 32'(nxt);
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    chk("bp_in_ready_low", {31'b0, ir0}, 32'd0);
    out_ready = 1'b1;
    rx = 0;
    for (int c = 0; c < 20 && rx < 5; c++) begin
      #1;
      if (ov0) begin rxv[rx] = oop0; rx++; end
      if (in_valid && ir0) begin acc++; nxt++; end
      @(negedge clk);
      if (nxt > 5) in_valid = 1'b0;
      else in_operand = 32'(nxt);
    end
    chk("bp_rx_count", 32'(rx), 32'd5);
    for (int i = 0; i < 5; i++) chk("bp_order", rxv[i], 32'(i + 1));
    #1 chk("bp_no_dup", {31'b0, ov0}, 32'd0);

    // Asynchronous reset with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h11223344, 2'b01, 2'b00);
    @(negedge clk); in_operand = 32'h55667788;
    @(negedge clk); in_valid = 1'b0;
    #1 chk("pre_rst_valid", {31'b0, ov0}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, ov0}, 32'd0);
    chk("arst_operand", oop0, 32'd0);
    chk("arst_sign_opc_prec", {24'b0, osg0, ooc0, opr0}, 32'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1 chk("post_rst_in_ready", {31'b0, ir0}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("post_rst_empty", {31'b0, ov0}, 32'd0);
    end

    // Flush with a same-cycle input offer
    @(negedge clk); drive(32'h01020304, 2'b00, 2'b00);
    @(negedge clk); in_operand = 32'h0A0B0C0D; flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk("flush_empty", {31'b0, ov0}, 32'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

// File: doc/tc_operand_pipe.md
TC_OPERAND_PIPE -- requirements
Module: tc_operand_pipe

Interface
REQ-001 SHALL have parameter LANE_W, default 8: lane width in bits, even, >=4.
REQ-002 SHALL have parameter NUM_LANES, default 4: lane count, multiple of 4.
REQ-003 SHALL have parameter OPERAND_SEL, default 0: 0 conditions operand A, 1 conditions operand B.
REQ-004 SHALL have these ports, with DATA_W = LANE_W*NUM_LANES:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_operand  in  DATA_W  raw operand.
- in_opcode  in  2  00 MUL, 01 MULH, 10 MULHU, 11 MULSU.
- in_precision  in  2  00 LANE_W, 01 2*LANE_W, 10 4*LANE_W, 11 alias of 00.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_operand  out  DATA_W  conditioned operand (magnitude).
- out_sign  out  NUM_LANES  per-lane negate flag.
- out_opcode  out  2  opcode carried with the beat.
- out_precision  out  2  precision carried with the beat.

Function
REQ-005 SHALL partition the operand into elements of E = LANE_W<<p bits, where p is 0, 1 or 2 for precision 00/11, 01 or 10; elements are aligned from bit 0.
REQ-006 SHALL treat an element as signed when OPERAND_SEL=0 and opcode is 00, 01 or 11, or when OPERAND_SEL=1 and opcode is 00 or 01.
REQ-007 SHALL set out_sign[k] = signed & MSB of the element containing lane k; all lanes of one element carry an identical flag.
REQ-008 SHALL output each flagged element as its two's complement modulo 2^E, with no carry or borrow crossing an element boundary; unflagged elements pass unchanged.
REQ-009 SHALL map the most-negative element value to itself (e.g. 0x80 -> 0x80 at E=8), so it reads as unsigned magnitude 2^(E-1).
REQ-010 SHALL be a 2-stage pipeline:
- S1 registers the operand, opcode, precision and per-lane sign flags.
- S2 registers the conditioned operand.
- Latency from acceptance to out_valid is exactly 2 cycles.
REQ-011 SHALL use stage-advance logic:
- s2_adv = ~s2_valid | out_ready.
- s1_adv = ~s1_valid | s2_adv.
- in_ready = s1_adv, combinational from state and out_ready only, never from in_valid.
REQ-012 SHALL sustain one beat per cycle when out_ready is held high.
REQ-013 SHALL hold out_operand, out_sign, out_opcode and out_precision stable while out_valid & ~out_ready.
REQ-014 SHALL neither drop, duplicate nor reorder beats under any out_ready pattern.
REQ-015 SHALL, when flush=1, clear s1_valid and s2_valid at the next edge; flush overrides a same-cycle input acceptance and output transfer, and data registers need not change.
REQ-016 SHALL treat precision 11 identically to 00 in both data and sign outputs.

Reset
REQ-017 SHALL, while rst=1 and independent of clk, force the following to 0:
- s1_valid, s2_valid, out_valid;
- out_operand, out_sign, out_opcode, out_precision.
REQ-018 SHALL drive in_ready=1 on the first cycle after rst deasserts.
REQ-019 SHALL discard any beats held in S1/S2 when rst is asserted mid-operation; nothing from them is ever presented after reset.

Verification
REQ-020 Defaults, OPERAND_SEL=0, MUL, precision 00, in 0x80FF017F, out_ready=1 -> 2 cycles later out_operand 0x8001017F, out_sign 4'b1100.
REQ-021 MULH, precision 01, in 0xFFFE8000 -> out_operand 0x00028000, out_sign 4'b1111; the same beat with precision 11 and in 0x00FF0000 -> 0x00010000, out_sign 4'b0100.
REQ-022 Precision 10, in 0xFFFFFFFF: MULHU -> 0xFFFFFFFF, sign 4'b0000; then MUL -> 0x00000001, sign 4'b1111 on consecutive cycles.
REQ-023 OPERAND_SEL=1, MULSU, precision 00, in 0x80808080 -> passthrough 0x80808080, sign 4'b0000; MUL on the same input -> 0x80808080, sign 4'b1111.
REQ-024 Backpressure: offer beats 1..5 continuously with out_ready=0 for 4 cycles, then 1 -> in_ready falls after 2 acceptances; all 5 beats appear in order exactly once; outputs stay stable while stalled.
REQ-025 With S1 and S2 valid, assert rst for 1 cycle -> out_valid and all outputs become 0 immediately; a separate run asserting flush with in_valid=1 -> no beat emerges from that cycle or earlier.
